// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register address width
// and the queued long-latency write request.
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipe and long-latency sources, issue/hazard
// queries, and the registered regfile write port.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic              pipe_we;
  logic [REG_AW-1:0] pipe_wa;
  logic [XLEN-1:0]   pipe_wd;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_wa;
  logic [XLEN-1:0]   lu_wd;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_wa;
  logic [REG_AW-1:0] pend_ra1;
  logic [REG_AW-1:0] pend_ra2;
  logic              pend1;
  logic              pend2;
  logic              we3;
  logic [REG_AW-1:0] wa3;
  logic [XLEN-1:0]   wd3;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output pipe_we, pipe_wa, pipe_wd,
    output lu_valid, lu_wa, lu_wd,
    output issue_valid, issue_wa,
    output pend_ra1, pend_ra2,
    input  lu_ready, pend1, pend2,
    input  we3, wa3, wd3, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd,
    input  lu_valid, lu_wa, lu_wd,
    input  issue_valid, issue_wa,
    input  pend_ra1, pend_ra2,
    output lu_ready, pend1, pend2,
    output we3, wa3, wd3, fifo_count
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO with occupancy count and async active-high reset.
// Push when full and pop when empty are ignored.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipe writes win, long-latency results queue in a
// FIFO, and a scoreboard tracks registers still owed a result.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter int NREG  = 32
) (
  input logic       clk,
  input logic       reset,
  wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t           w_din;
  wb_req_t           w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              w_pipe_sel;
  logic              w_pop;
  logic              w_push;
  logic              w_we_nxt;
  logic [REG_AW-1:0] w_wa_nxt;
  logic [XLEN-1:0]   w_wd_nxt;
  logic [NREG-1:0]   w_pend_nxt;

  logic              r_we;
  logic [REG_AW-1:0] r_wa;
  logic [XLEN-1:0]   r_wd;
  logic [NREG-1:0]   r_pend;

  assign w_din      = '{wa: bus.lu_wa, wd: bus.lu_wd};
  assign w_pipe_sel = bus.pipe_we && (bus.pipe_wa != '0);
  assign w_pop      = !w_pipe_sel && !w_empty;
  // r0 results are consumed here so they never occupy a slot
  assign w_push     = bus.lu_valid && !w_full && (bus.lu_wa != '0);

  wb_fifo #(
    .W     ($bits(wb_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_we_nxt = 1'b0;
    w_wa_nxt = r_wa;
    w_wd_nxt = r_wd;
    unique case (1'b1)
      w_pipe_sel: begin
        w_we_nxt = 1'b1;
        w_wa_nxt = bus.pipe_wa;
        w_wd_nxt = bus.pipe_wd;
      end
      w_pop: begin
        w_we_nxt = 1'b1;
        w_wa_nxt = w_head.wa;
        w_wd_nxt = w_head.wd;
      end
      default: ;
    endcase
  end

  // a new issue to the same register outranks the drain of the old one
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop) w_pend_nxt[w_head.wa] = 1'b0;
    if (bus.issue_valid && (bus.issue_wa != '0))
      w_pend_nxt[bus.issue_wa] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_pend <= '0;
    end else begin
      r_we   <= w_we_nxt;
      r_wa   <= w_wa_nxt;
      r_wd   <= w_wd_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  assign bus.lu_ready   = !w_full;
  assign bus.fifo_count = w_count;
  assign bus.we3        = r_we;
  assign bus.wa3        = r_wa;
  assign bus.wd3        = r_wd;
  assign bus.pend1      = r_pend[bus.pend_ra1];
  assign bus.pend2      = r_pend[bus.pend_ra2];
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(32), .DEPTH(DEPTH)) bus();

  wb_arbiter #(
    .XLEN  (32),
    .DEPTH (DEPTH),
    .NREG  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  wb_req_t     m_q[$];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.pipe_we     = 1'b0;
    bus.pipe_wa     = '0;
    bus.pipe_wd     = '0;
    bus.lu_valid    = 1'b0;
    bus.lu_wa       = '0;
    bus.lu_wd       = '0;
    bus.issue_valid = 1'b0;
    bus.issue_wa    = '0;
  endtask

  task automatic cycle();
    logic    sel;
    logic    ready;
    wb_req_t h;
    @(negedge clk);
    chk("we3", 64'(bus.we3), 64'(m_we));
    chk("wa3", 64'(bus.wa3), 64'(m_wa));
    chk("wd3", 64'(bus.wd3), 64'(m_wd));
    chk("count", 64'(bus.fifo_count), 64'(m_q.size()));
    ready = (m_q.size() < DEPTH);
    chk("lu_ready", 64'(bus.lu_ready), 64'(ready));
    chk("pend1", 64'(bus.pend1), 64'(m_pend[bus.pend_ra1]));
    chk("pend2", 64'(bus.pend2), 64'(m_pend[bus.pend_ra2]));
    sel = bus.pipe_we && (bus.pipe_wa != 0);
    if (sel) begin
      m_we = 1'b1;
      m_wa = bus.pipe_wa;
      m_wd = bus.pipe_wd;
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
      m_we = 1'b1;
      m_wa = h.wa;
      m_wd = h.wd;
      m_pend[h.wa] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (bus.lu_valid && ready && bus.lu_wa != 0)
      m_q.push_back('{wa: bus.lu_wa, wd: bus.lu_wd});
    if (bus.issue_valid && bus.issue_wa != 0)
      m_pend[bus.issue_wa] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_we3", 64'(bus.we3), 64'd0);
    chk("rst_wa3", 64'(bus.wa3), 64'd0);
    chk("rst_wd3", 64'(bus.wd3), 64'd0);
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_ready", 64'(bus.lu_ready), 64'd1);
    chk("rst_pend1", 64'(bus.pend1), 64'd0);
    chk("rst_pend2", 64'(bus.pend2), 64'd0);
    m_q.delete();
    m_pend = '0;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.pipe_we     = ($urandom_range(0, 1) == 1);
    bus.pipe_wa     = 5'($urandom_range(0, 7));
    bus.pipe_wd     = $urandom;
    bus.lu_valid    = ($urandom_range(0, 4) < 2);
    bus.lu_wa       = 5'($urandom_range(0, 7));
    bus.lu_wd       = $urandom;
    bus.issue_valid = ($urandom_range(0, 4) == 0);
    bus.issue_wa    = 5'($urandom_range(0, 7));
    bus.pend_ra1    = 5'($urandom_range(0, 7));
    bus.pend_ra2    = 5'($urandom_range(0, 7));
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < DEPTH + 2; i++) cycle();
  endtask

  initial begin
    idle();
    bus.pend_ra1 = '0;
    bus.pend_ra2 = '0;
    do_reset();

    // 1: reset mid-stream, then a single pipe write
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      cycle();
    end
    do_reset();
    idle();
    bus.pipe_we = 1'b1;
    bus.pipe_wa = 5'd5;
    bus.pipe_wd = 32'hDEADBEEF;
    cycle();
    chk("t1_we", 64'(bus.we3), 64'd1);
    chk("t1_wa", 64'(bus.wa3), 64'd5);
    chk("t1_wd", 64'(bus.wd3), 64'hDEADBEEF);
    idle();
    cycle();
    chk("t1_off", 64'(bus.we3), 64'd0);

    // 2: issue then long-latency completion
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_wa = 5'd9;
    bus.pend_ra1 = 5'd9;
    cycle();
    idle();
    cycle();
    chk("t2_pend", 64'(bus.pend1), 64'd1);
    bus.lu_valid = 1'b1;
    bus.lu_wa = 5'd9;
    bus.lu_wd = 32'd42;
    cycle();
    idle();
    cycle();
    chk("t2_we", 64'(bus.we3), 64'd1);
    chk("t2_wa", 64'(bus.wa3), 64'd9);
    chk("t2_wd", 64'(bus.wd3), 64'd42);
    chk("t2_clr", 64'(bus.pend1), 64'd0);
    drain();

    // 3: pipe conflicts with a queued entry
    bus.pipe_we = 1'b1;
    bus.pipe_wa = 5'd4;
    bus.pipe_wd = 32'd1;
    bus.lu_valid = 1'b1;
    bus.lu_wa = 5'd3;
    bus.lu_wd = 32'd7;
    cycle();
    bus.lu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_cnt", 64'(bus.fifo_count), 64'd1);
      chk("t3_wa", 64'(bus.wa3), 64'd4);
    end
    idle();
    cycle();
    chk("t3_pop", 64'(bus.wd3), 64'd7);
    drain();

    // 4: fill to DEPTH under continuous pipe traffic
    bus.pipe_we = 1'b1;
    bus.pipe_wa = 5'd10;
    for (int k = 1; k <= 4; k++) begin
      bus.pipe_wd = 32'(k);
      bus.lu_valid = 1'b1;
      bus.lu_wa = 5'(k);
      bus.lu_wd = 32'(10 + k);
      cycle();
    end
    chk("t4_cnt", 64'(bus.fifo_count), 64'd4);
    chk("t4_ready", 64'(bus.lu_ready), 64'd0);
    bus.lu_wa = 5'd5;
    bus.lu_wd = 32'd15;
    cycle();
    chk("t4_nopush", 64'(bus.fifo_count), 64'd4);
    idle();
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("t4_drain", 64'(bus.wd3), 64'(10 + k));
    end
    chk("t4_ready1", 64'(bus.lu_ready), 64'd1);
    drain();

    // 5: r0 writes
    bus.pipe_we = 1'b1;
    bus.pipe_wa = 5'd8;
    bus.pipe_wd = 32'd88;
    bus.lu_valid = 1'b1;
    bus.lu_wa = 5'd7;
    bus.lu_wd = 32'd77;
    cycle();
    bus.pipe_wa = 5'd0;
    bus.pipe_wd = 32'd123;
    bus.lu_wa = 5'd0;
    bus.lu_wd = 32'd99;
    bus.issue_valid = 1'b1;
    bus.issue_wa = 5'd0;
    bus.pend_ra1 = 5'd0;
    cycle();
    chk("t5_wa", 64'(bus.wa3), 64'd7);
    chk("t5_wd", 64'(bus.wd3), 64'd77);
    chk("t5_cnt", 64'(bus.fifo_count), 64'd0);
    chk("t5_pend0", 64'(bus.pend1), 64'd0);
    drain();

    // 6: set/clear race on r6
    bus.issue_valid = 1'b1;
    bus.issue_wa = 5'd6;
    bus.pend_ra2 = 5'd6;
    cycle();
    idle();
    bus.pipe_we = 1'b1;
    bus.pipe_wa = 5'd10;
    bus.lu_valid = 1'b1;
    bus.lu_wa = 5'd6;
    bus.lu_wd = 32'd66;
    cycle();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_wa = 5'd6;
    cycle();
    chk("t6_wa", 64'(bus.wa3), 64'd6);
    chk("t6_pend", 64'(bus.pend2), 64'd1);
    drain();

    // random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the three-ported register file.
- Merges two result sources onto the file's single write port (we3/wa3/wd3):
  - the in-order pipeline writeback, which is never stalled;
  - a long-latency unit (mul/div), buffered in a small FIFO.
- Keeps a per-register pending scoreboard so the hazard unit can stall readers of registers still owed a long-latency result.

Parameters:
- XLEN, 32, data width.
- DEPTH, 4, long-latency FIFO entries; power of two, at least 2.
- NREG, 32, architectural registers; address width is $clog2(NREG) = 5.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pipe_we  in  1  pipeline writeback valid.
- pipe_wa  in  5  pipeline destination register.
- pipe_wd  in  XLEN  pipeline result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_wa  in  5  long-latency destination register.
- lu_wd  in  XLEN  long-latency result.
- issue_valid  in  1  a long-latency op is issued this cycle.
- issue_wa  in  5  destination register of the issued op.
- pend_ra1  in  5  hazard query address 1.
- pend_ra2  in  5  hazard query address 2.
- pend1  out  1  register pend_ra1 is awaiting a long-latency result.
- pend2  out  1  register pend_ra2 is awaiting a long-latency result.
- we3  out  1  regfile write enable (registered).
- wa3  out  5  regfile write address (registered).
- wd3  out  XLEN  regfile write data (registered).
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous and active-high:
  - we3=0, wa3=0, wd3=0;
  - FIFO empty, fifo_count=0;
  - all scoreboard bits cleared;
  - lu_ready=1, pend1=0, pend2=0.
- Latency: a selected write appears on we3/wa3/wd3 one cycle after selection; the regfile commits it on the following edge.
- Selection, evaluated each cycle:
  - if pipe_we=1 and pipe_wa!=0, the pipe write wins;
  - else, if the FIFO is non-empty, pop the head;
  - else drive we3=0 next cycle, with wa3/wd3 holding their last values.
- Pipeline writes are never back-pressured. A pipe write with pipe_wa=0 is dropped and does not block a FIFO pop that cycle.
- FIFO push:
  - push occurs when lu_valid && lu_ready;
  - an entry with lu_wa=0 is accepted and discarded (no push).
- lu_ready = (fifo_count < DEPTH). It does not look ahead to a same-cycle pop.
- Push and pop in the same cycle: count is unchanged and ordering is preserved (FIFO order, oldest first).
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH, with a separate count.
- Scoreboard (NREG bits):
  - set on issue_valid when issue_wa!=0;
  - cleared when a FIFO entry for that register is popped;
  - same-register set and clear in the same cycle: set wins;
  - bit 0 is held at 0;
  - pipe writes never touch the scoreboard.
- pend1 and pend2 are combinational reads of the scoreboard bits, so they reflect updates from the previous edge.
- Reset mid-operation discards all queued entries and pending bits. No partial write is emitted after reset deasserts.

Decomposition:
- Shared package wb_pkg holds:
  - constant REG_AW=5;
  - typedef wb_req_t {logic [4:0] wa; logic [XLEN-1:0] wd;}.
- One sub-module, wb_fifo: a parameterized synchronous FIFO (push, pop, full, empty, count) with asynchronous active-high reset.
- Arbitration, the scoreboard and the output register stay in wb_arbiter.

Test Plan:
1. Reset, then a single pipe write.
   - Stimulus: assert reset mid-stream, then pipe_we=1, pipe_wa=5, pipe_wd=32'hDEADBEEF for one cycle.
   - Response: all outputs are 0 while reset is asserted; after reset, the next cycle shows we3=1, wa3=5, wd3=DEADBEEF, then we3=0.
2. Issue, then long-latency completion.
   - Stimulus: issue_wa=9; later lu_valid=1, lu_wa=9, lu_wd=42 with no pipe traffic.
   - Response: pend1=1 for pend_ra1=9 until the cycle after the write drains. The write appears as we3=1, wa3=9, wd3=42, two cycles after lu_valid.
3. Conflict.
   - Stimulus: FIFO holds {r3=7}; the pipe writes r4=1 for 3 consecutive cycles.
   - Response: the output sequence is r4, r4, r4, then r3=7. fifo_count stays at 1 until the pop.
4. Full.
   - Stimulus: push 4 entries r1..r4 (=11..14) while the pipe writes continuously.
   - Response: fifo_count=4 and lu_ready=0. A 5th lu_valid is not accepted. Once the pipe idles, the drain order is 11, 12, 13, 14 and lu_ready returns to 1.
5. Zero-register writes.
   - Stimulus: pipe_wa=0 write alongside a non-empty FIFO, plus lu_wa=0 and issue_wa=0.
   - Response: the FIFO head is popped the same cycle; no write to r0 is ever emitted; pend is never 1 for register 0.
6. Set/clear race.
   - Stimulus: r6 is at the FIFO head and popped in the same cycle that issue_valid arrives with issue_wa=6.
   - Response: the scoreboard bit for r6 remains 1 after the edge.
